// File: rtl/openram_march_sequencer.sv
// openram_march_sequencer
// Self-contained March C- initiator for the OpenRAM test chip. It walks one
// 32-bit SRAM through W0 up, R0W1 up, R1W0 down and R0 down, emitting one
// 86-bit LA packet per operation slot. It checks the returned read data and
// records the pass/fail result, the miscompare count and the first failure.
//
// Ports
//   wb_clock          single clock for all logic
//   reset             synchronous, active-high
//   start             one-cycle run request, honoured only when idle
//   abort             stop a run and return to idle (wins over start)
//   last_addr         highest address tested, sampled with start
//   pattern           background data, sampled with start
//   sram_data         read data from the test chip, bits [31:0] compared
//   la_packet         packet presented to the test chip
//   busy              run in progress
//   done              run completed, held until next accepted start/reset
//   pass              done with zero miscompares
//   fail_count        saturating miscompare count
//   first_fail_addr   address of the first miscompare
//   first_fail_data   read data captured at the first miscompare
module openram_march_sequencer #(
  parameter int unsigned SRAM_ID      = 0,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  wb_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic [31:0]           pattern,
  input  logic [63:0]           sram_data,
  output logic [85:0]           la_packet,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           fail_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic [31:0]           first_fail_data
);

  localparam int unsigned SLOT = READ_LATENCY + 1;
  localparam int unsigned SW   = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W0_UP,
    ST_R0W1_UP,
    ST_R1W0_DN,
    ST_R0_DN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_phase_q, wr_phase_d;  // second half of a read-write pair
  logic [SW-1:0]         slot_q, slot_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [31:0]           pat_q, pat_d;
  logic [15:0]           fail_count_q, fail_count_d;
  logic [ADDR_WIDTH-1:0] ffa_q, ffa_d;
  logic [31:0]           ffd_q, ffd_d;
  logic                  done_q, done_d;

  // Operation decode for the current slot, shared by packet and checker.
  logic        op_read;
  logic [31:0] exp_data;
  logic [31:0] wr_data;
  logic        slot_end;

  // Only the low word carries data from a 32-bit macro.
  logic unused_sram_hi;
  assign unused_sram_hi = ^sram_data[63:32];

  // State register.
  // NOTE: the reset here is synchronous, so it lives inside the clocked
  // branch rather than in the sensitivity list.
  always_ff @(posedge wb_clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wr_phase_q   <= 1'b0;
      slot_q       <= '0;
      last_q       <= '0;
      pat_q        <= '0;
      fail_count_q <= '0;
      ffa_q        <= '0;
      ffd_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q      <= state_d;
      addr_q       <= addr_d;
      wr_phase_q   <= wr_phase_d;
      slot_q       <= slot_d;
      last_q       <= last_d;
      pat_q        <= pat_d;
      fail_count_q <= fail_count_d;
      ffa_q        <= ffa_d;
      ffd_q        <= ffd_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every target gets a hold default first so no path infers a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    wr_phase_d   = wr_phase_q;
    slot_d       = slot_q;
    last_d       = last_q;
    pat_d        = pat_q;
    fail_count_d = fail_count_q;
    ffa_d        = ffa_q;
    ffd_d        = ffd_q;
    done_d       = done_q;

    if (state_q == ST_IDLE) begin
      if (start && !abort) begin
        state_d      = ST_W0_UP;
        addr_d       = '0;
        wr_phase_d   = 1'b0;
        slot_d       = '0;
        last_d       = last_addr;
        pat_d        = pattern;
        fail_count_d = '0;
        ffa_d        = '0;
        ffd_d        = '0;
        done_d       = 1'b0;
      end
    end else if (abort) begin
      state_d = ST_IDLE;
    end else begin
      slot_d = slot_end ? '0 : slot_q + 1'b1;
      if (slot_end) begin
        // Read data is valid in the final cycle of the slot.
        if (op_read && (sram_data[31:0] != exp_data)) begin
          if (fail_count_q != 16'hFFFF) fail_count_d = fail_count_q + 16'd1;
          if (fail_count_q == 16'd0) begin
            ffa_d = addr_q;
            ffd_d = sram_data[31:0];
          end
        end
        // Bounds are checked against the latched limit so the counter
        // never wraps, even for last_addr of all ones.
        unique case (state_q)
          ST_W0_UP: begin
            if (addr_q == last_q) begin
              state_d = ST_R0W1_UP;
              addr_d  = '0;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end
          ST_R0W1_UP: begin
            wr_phase_d = !wr_phase_q;
            if (wr_phase_q) begin
              if (addr_q == last_q) begin
                state_d = ST_R1W0_DN;
                addr_d  = last_q;
              end else begin
                addr_d = addr_q + 1'b1;
              end
            end
          end
          ST_R1W0_DN: begin
            wr_phase_d = !wr_phase_q;
            if (wr_phase_q) begin
              if (addr_q == '0) begin
                state_d = ST_R0_DN;
                addr_d  = last_q;
              end else begin
                addr_d = addr_q - 1'b1;
              end
            end
          end
          ST_R0_DN: begin
            if (addr_q == '0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              addr_d = addr_q - 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Output logic: packet is a pure function of registered state, so it is
  // stable for the whole slot.
  always_comb begin
    logic [9:0] addr_field;
    addr_field = 10'(addr_q);
    slot_end   = (slot_q == SLOT_LAST);
    op_read    = ((state_q == ST_R0W1_UP || state_q == ST_R1W0_DN) && !wr_phase_q)
                 || (state_q == ST_R0_DN);
    exp_data   = (state_q == ST_R1W0_DN) ? ~pat_q : pat_q;
    wr_data    = (state_q == ST_R0W1_UP) ? ~pat_q : pat_q;

    // Idle packet: both ports deselected.
    la_packet = {3'(SRAM_ID), 1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b1, 10'h0, 24'h0};
    if (state_q != ST_IDLE) begin
      if (op_read)
        la_packet = {3'(SRAM_ID), 1'b0, 1'b1, 4'h0, addr_field, 32'h0, 1'b1, 10'h0, 24'h0};
      else
        la_packet = {3'(SRAM_ID), 1'b0, 1'b0, 4'hF, addr_field, wr_data, 1'b1, 10'h0, 24'h0};
    end

    busy            = (state_q != ST_IDLE);
    done            = done_q;
    pass            = done_q && (fail_count_q == 16'd0);
    fail_count      = fail_count_q;
    first_fail_addr = ffa_q;
    first_fail_data = ffd_q;
  end

endmodule

// File: tb/tb_openram_march_sequencer.sv
// Scoreboard bench for openram_march_sequencer. Expected packets and run
// results are queued when a run is launched, then popped as the DUT
// produces packets each cycle and when busy falls.
module tb_openram_march_sequencer;

  localparam int unsigned SRAM_ID    = 0;
  localparam int unsigned AW         = 10;
  localparam int unsigned RL         = 2;
  localparam int unsigned S          = RL + 1;
  localparam logic [9:0]  FAULT_ADDR = 10'd2;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [AW-1:0] last_addr;
  logic [31:0]   pattern;
  logic [63:0]   sram_data;
  logic [85:0]   la_packet;
  logic          busy, done, pass;
  logic [15:0]   fail_count;
  logic [AW-1:0] first_fail_addr;
  logic [31:0]   first_fail_data;

  typedef struct {
    int          cycles;
    logic        done;
    logic        pass;
    logic [15:0] fail_count;
    logic [AW-1:0] ffa;
    logic [31:0] ffd;
  } result_t;

  logic [85:0] pkt_q [$];
  result_t     res_q [$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          fault_on = 1'b0;

  always #5 clk = ~clk;

  openram_march_sequencer #(
    .SRAM_ID(SRAM_ID), .ADDR_WIDTH(AW), .READ_LATENCY(RL)
  ) dut (
    .wb_clock(clk), .reset(reset), .start(start), .abort(abort),
    .last_addr(last_addr), .pattern(pattern), .sram_data(sram_data),
    .la_packet(la_packet), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail_addr(first_fail_addr),
    .first_fail_data(first_fail_data)
  );

  // Test-chip SRAM: two-cycle read pipeline, optional bit-0 stuck-at-0 cell.
  logic [31:0] mem [0:1023];
  logic [31:0] rd0, rd1;
  always @(posedge clk) begin
    if (!la_packet[82]) begin
      if (!la_packet[81])
        mem[la_packet[76:67]] <= (fault_on && la_packet[76:67] == FAULT_ADDR)
                                 ? (la_packet[66:35] & ~32'h1) : la_packet[66:35];
      else
        rd0 <= mem[la_packet[76:67]];
    end
    rd1 <= rd0;
  end
  assign sram_data = {32'hDEADBEEF, rd1};

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [85:0] mk_idle();
    return {3'(SRAM_ID), 1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b1, 10'h0, 24'h0};
  endfunction

  function automatic logic [85:0] mk_rd(input int a);
    return {3'(SRAM_ID), 1'b0, 1'b1, 4'h0, 10'(a), 32'h0, 1'b1, 10'h0, 24'h0};
  endfunction

  function automatic logic [85:0] mk_wr(input int a, input logic [31:0] d);
    return {3'(SRAM_ID), 1'b0, 1'b0, 4'hF, 10'(a), d, 1'b1, 10'h0, 24'h0};
  endfunction

  task automatic push_slot(input logic [85:0] p);
    for (int k = 0; k < S; k++) pkt_q.push_back(p);
  endtask

  // Reference march over an array model with the same fault, giving the
  // expected miscompare statistics.
  task automatic model(input int n, input logic [31:0] pat, input bit fault,
                       output logic [15:0] fc, output logic [AW-1:0] fa,
                       output logic [31:0] fd);
    logic [31:0] m [0:1023];
    logic [31:0] v, e;
    fc = 0; fa = 0; fd = 0;
    for (int el = 0; el < 4; el++) begin
      for (int i = 0; i < n; i++) begin
        int a;
        a = (el < 2) ? i : n - 1 - i;
        if (el > 0) begin
          v = m[a];
          e = (el == 2) ? ~pat : pat;
          if (v != e) begin
            if (fc == 0) begin fa = AW'(a); fd = v; end
            if (fc != 16'hFFFF) fc++;
          end
        end
        if (el < 3) begin
          v = (el == 1) ? ~pat : pat;
          if (fault && a == int'(FAULT_ADDR)) v[0] = 1'b0;
          m[a] = v;
        end
      end
    end
  endtask

  task automatic run(input int last, input logic [31:0] pat, input bit fault,
                     input int restart_at, input int abort_at, input int reset_at);
    int      n, cyc;
    result_t r;
    n = last + 1;
    fault_on = fault;
    pkt_q.delete();
    for (int a = 0; a < n; a++) push_slot(mk_wr(a, pat));
    for (int a = 0; a < n; a++) begin push_slot(mk_rd(a)); push_slot(mk_wr(a, ~pat)); end
    for (int a = n - 1; a >= 0; a--) begin push_slot(mk_rd(a)); push_slot(mk_wr(a, pat)); end
    for (int a = n - 1; a >= 0; a--) push_slot(mk_rd(a));

    if (abort_at >= 0 || reset_at >= 0) begin
      r.cycles = (abort_at >= 0) ? abort_at + 1 : reset_at + 1;
      r.done = 0; r.pass = 0; r.fail_count = 0; r.ffa = 0; r.ffd = 0;
    end else begin
      r.cycles = 6 * n * S;
      model(n, pat, fault, r.fail_count, r.ffa, r.ffd);
      r.done = 1;
      r.pass = (r.fail_count == 0);
    end
    res_q.push_back(r);

    last_addr = AW'(last); pattern = pat; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 5000) begin
      if (pkt_q.size() > 0) check("pkt", la_packet, pkt_q.pop_front());
      else check("pkt_overrun", 1, 0);
      if (cyc == 0) begin
        check("first_addr0", la_packet[76:67], 0);
        check("first_din0", la_packet[66:35], pat);
        check("first_web0", la_packet[81], 0);
      end
      start = (cyc == restart_at);
      abort = (cyc == abort_at);
      reset = (cyc == reset_at);
      @(posedge clk); #1;
      cyc++;
      start = 1'b0; abort = 1'b0; reset = 1'b0;
    end

    r = res_q.pop_front();
    check("busy_cycles", cyc, r.cycles);
    check("done", done, r.done);
    check("pass", pass, r.pass);
    check("fail_count", fail_count, r.fail_count);
    check("first_fail_addr", first_fail_addr, r.ffa);
    check("first_fail_data", first_fail_data, r.ffd);
    check("idle_pkt", la_packet, mk_idle());
    if (r.done) begin
      repeat (3) @(posedge clk);
      #1;
      check("done_hold", {done, pass, busy}, {r.done, r.pass, 1'b0});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; last_addr = '0; pattern = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail_count", fail_count, 0);
    check("rst_ffa_ffd", {first_fail_addr, first_fail_data}, 0);
    check("rst_pkt", la_packet, mk_idle());
    reset = 1'b0;
    @(posedge clk); #1;

    // Clean run, N=4.
    run(3, 32'h5555AAAA, 1'b0, -1, -1, -1);

    // Start and abort together in idle: abort wins, results untouched.
    start = 1'b1; abort = 1'b1; last_addr = AW'(7);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_done", done, 1);

    // Stuck-at-0 on bit 0 at address 2.
    run(3, 32'h5555AAAA, 1'b1, -1, -1, -1);
    // Single-address run.
    run(0, 32'h5555AAAA, 1'b0, -1, -1, -1);
    // Start pulsed while busy is ignored.
    run(3, 32'h5555AAAA, 1'b0, 10, -1, -1);
    // Abort mid-run, then a fresh run completes.
    run(3, 32'h5555AAAA, 1'b0, -1, 30, -1);
    run(3, 32'h0F0F1234, 1'b0, -1, -1, -1);
    // Reset during R1W0_DN (cycles 36..59 for N=4).
    run(3, 32'h5555AAAA, 1'b0, -1, -1, 40);
    // Wider run with fault after reset.
    run(5, 32'hC3C3_3C3C, 1'b1, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/openram_march_sequencer.md
Name: openram_march_sequencer

Overview:
- On-chip packet initiator for the OpenRAM test chip. It generates the 86-bit LA packet stream that the test-chip control logic consumes, and checks the returned sram_data.
- Runs a March C- style sequence (W0 up, R0W1 up, R1W0 down, R0 down) over one selected 32-bit SRAM.
- Records pass/fail, fail count and the first failing address/data. This replaces hand-written packet sequences in benches and firmware.

Parameters:
- SRAM_ID, 0, value placed in the packet sram_id field (0..4; 32-bit macros only)
- ADDR_WIDTH, 10, width of the address counter and of last_addr (addr0 field is 10 bits; upper bits zero when narrower)
- READ_LATENCY, 2, cycles from packet presentation to valid sram_data; slot length S = READ_LATENCY+1

Ports:
- wb_clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; honoured only in IDLE
- abort  in  1  stop the run, return to IDLE
- last_addr  in  ADDR_WIDTH  highest address tested, sampled with start; N = last_addr+1
- pattern  in  32  background data, sampled with start
- sram_data  in  64  read data returned by the test chip; bits [31:0] compared
- la_packet  out  86  packet to test chip
- busy  out  1  run in progress
- done  out  1  run completed (level)
- pass  out  1  done && fail_count==0
- fail_count  out  16  number of miscompares, saturating at 16'hFFFF
- first_fail_addr  out  ADDR_WIDTH  address of first miscompare
- first_fail_data  out  32  sram_data[31:0] captured at first miscompare

Behaviour:
- Reset is synchronous and active-high on wb_clock (decided).
- Packet fields:
  - [85:83] sram_id
  - [82] csb0
  - [81] web0
  - [80:77] wmask0
  - [76:67] addr0
  - [66:35] din0
  - [34] csb1
  - [33:24] addr1
  - [23:0] zero
- IDLE packet: sram_id=SRAM_ID, csb0=1, web0=1, csb1=1, all other fields 0.
- Reset values: la_packet=IDLE packet, busy=0, done=0, pass=0, fail_count=0, first_fail_addr=0, first_fail_data=0, state=IDLE.
- States: IDLE, W0_UP, R0W1_UP, R1W0_DN, R0_DN.
- IDLE + start:
  - latch last_addr and pattern
  - clear done, pass, fail_count, first_fail_*
  - enter W0_UP at addr 0; busy=1 from the next cycle.
- Each operation occupies one slot of S cycles. la_packet is held stable for the whole slot.
  - Write: csb0=0, web0=0, wmask0=4'hF, din0=data.
  - Read: csb0=0, web0=1, wmask0=0, din0=0.
  - Read compare happens in the last cycle of the slot: sram_data[31:0] against the expected value.
- Element sequence:
  - W0_UP: addr 0..N-1, write pattern.
  - R0W1_UP: addr 0..N-1, read expecting pattern, then write ~pattern.
  - R1W0_DN: addr N-1..0, read expecting ~pattern, then write pattern.
  - R0_DN: addr N-1..0, read expecting pattern.
- Total run: 6N slots = 6·N·S cycles.
- Element transitions: after the final slot at the last address (N-1 going up, 0 going down), move to the next element. Its starting address is 0 for up elements and N-1 for down elements.
- Miscompare handling:
  - fail_count increments, saturating at 16'hFFFF.
  - If fail_count was 0, capture first_fail_addr and first_fail_data.
- Completion:
  - The cycle after the last R0_DN slot: state=IDLE, busy=0, done=1, pass=(fail_count==0), la_packet=IDLE packet.
  - done and the results hold until the next accepted start or reset.
- Boundaries and simultaneous events:
  - last_addr=0: N=1, and both up and down elements touch only addr 0.
  - start while busy: ignored.
  - abort while busy: next cycle state=IDLE, busy=0, la_packet=IDLE packet, done stays 0, counters keep partial values.
  - abort and start together in IDLE: abort wins, start is ignored.
  - reset mid-run: all outputs return to reset values on the next edge.
- Address counter must not wrap: bounds are compared against the latched last_addr.

Test Plan:
- READ_LATENCY=2, ideal SRAM model, last_addr=3, pattern=32'h5555AAAA, pulse start:
  - busy high exactly 72 cycles, then done=1, pass=1, fail_count=0.
  - First slot packet: addr0=0, din0=32'h5555AAAA, web0=0.
- Same setup with a bit-0 stuck-at-0 fault at addr 2:
  - fail_count=1, first_fail_addr=2, first_fail_data=32'hAAAA5554, pass=0.
- last_addr=0:
  - busy for 18 cycles; packet addr0 stays 0 throughout; done=1, pass=1.
- Pulse start again at cycle 10 of a run:
  - no restart; completion timing unchanged at 72 cycles.
- Abort at cycle 30:
  - next cycle busy=0, done=0, la_packet=IDLE packet (csb0=1, web0=1, csb1=1).
  - A new start afterwards runs to pass=1.
- Assert reset mid-R1W0_DN:
  - next edge busy=0, done=0, fail_count=0, la_packet=IDLE packet.
